mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter and access sequencer for the shared 4096 x 16 main memory. The CPU instruction-cycle path and the I/O transfer path each issue single-word read/write requests. The arbiter grants one requester at a time, latches its command, drives the memory port for a fixed number of wait cycles, and returns read data with a one-cycle done pulse. It sits between the control unit / AR-DR datapath and the memory array, replacing direct AR-addressed memory access.

## Interface
- AW, 12, address width (4096 words)
- DW, 16, data width
- WAIT, 1, extra memory cycles per access; legal range 0..15; ACCESS phase lasts WAIT+1 cycles
- CLK  in  1  system clock; all state changes on rising edge
- RST  in  1  reset; asynchronous, active-high
- cpu_req  in  1  CPU access request; level
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU word address
- cpu_wdata  in  DW  CPU write data
- cpu_gnt  out  1  CPU owns memory (ACCESS and DONE)
- cpu_done  out  1  one-cycle completion pulse
- cpu_rdata  out  DW  registered read data; holds until next CPU read completes
- io_req, io_we, io_addr, io_wdata, io_gnt, io_done, io_rdata: same as the cpu_* ports, for the I/O requester
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable; only high with mem_en
- mem_addr  out  AW  latched address
- mem_wdata  out  DW  latched write data
- mem_rdata  in  DW  memory read data; valid by end of the last ACCESS cycle
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: sample cpu_req and io_req at the rising edge.
  - One request: grant it.
  - Both requests: grant the requester not served last (round-robin).
  - No request: stay in IDLE.
- Grant edge:
  - Latch we, addr and wdata of the winner into internal registers.
  - Load the wait counter with WAIT.
  - Go to ACCESS.
  - Requester inputs are ignored from this edge until the next IDLE sample.
- ACCESS: mem_en=1, mem_we=latched we, mem_addr/mem_wdata=latched values, winner's gnt=1.
  - Counter decrements each cycle.
  - When counter==0: capture mem_rdata into the winner's rdata register (reads only; writes leave rdata unchanged), update the last-served pointer, and go to DONE.
- DONE: winner's gnt=1 and done=1, mem_en=0, mem_we=0. Next state is unconditionally IDLE.
- Requester rule: deassert req in the cycle after done. A req still high at the IDLE sample is a new request.
- Non-winner's gnt and done stay 0 throughout.
- mem_addr and mem_wdata hold their last latched values outside ACCESS. mem_en=0 qualifies them.

## Timing
- Reset values (asynchronous, immediate on RST high):
  - State: IDLE.
  - Outputs: all gnt/done=0, mem_en=0, mem_we=0, busy=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, io_rdata=0.
  - Last-served pointer: IO, so the CPU wins the first tie.
- Latency: req high in cycle 0 (IDLE).
  - Cycle 1: gnt=1.
  - Cycles 1..WAIT+1: mem_en=1.
  - Cycle WAIT+2: done=1, rdata valid.
  - Cycle WAIT+3: IDLE.
- Throughput under continuous requests: one access per WAIT+3 cycles.
- Reset mid-ACCESS or mid-DONE: the transaction is aborted with no done pulse. mem_en drops asynchronously. Memory contents at the aborted address are undefined for writes. After RST falls, requests are re-evaluated from IDLE with CPU priority.
- A request arriving during ACCESS/DONE waits. It is served at the next IDLE sample, subject to round-robin.
- WAIT=0: ACCESS is a single cycle; done in cycle 2.

## Test plan
- Reset: RST high with both reqs high → all outputs 0, busy=0; after RST low, cpu_gnt rises one cycle after the first IDLE edge.
- CPU read, WAIT=1, mem[0x007]=0x0001: cpu_req, addr 0x007 in cycle 0 → mem_en cycles 1-2, mem_addr=0x007, cpu_gnt cycles 1-3, cpu_done cycle 3 only, cpu_rdata=0x0001 from cycle 3.
- IO write then CPU read: io_we=1, addr 0x009, wdata 0x0003 → mem_we=1, mem_wdata=0x0003 cycles 1-2, io_done cycle 3, io_rdata unchanged; a following CPU read of 0x009 returns 0x0003.
- Contention: both reqs held high continuously after reset → grant order CPU, IO, CPU, IO; done pulses alternate every 4 cycles (WAIT=1); no cycle has both gnts high.
- Command latching: cpu_addr changes 0x007→0x008 in cycle 2 → mem_addr stays 0x007; cpu_rdata=mem[0x007].
- Reset mid-ACCESS: RST pulsed in cycle 2 of a CPU write → mem_en, mem_we and cpu_gnt drop in the same cycle, no cpu_done; the held cpu_req is re-granted after release and completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer for two single-word memory requesters; done arrives WAIT+2 cycles after a sampled req.
// No backpressure: a losing or late request simply stays pending until the next IDLE sample.
module mem_arbiter #(
  parameter int AW   = 12,
  parameter int DW   = 16,
  parameter int WAIT = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  output logic [DW-1:0] cpu_rdata,
  input  logic          io_req,
  input  logic          io_we,
  input  logic [AW-1:0] io_addr,
  input  logic [DW-1:0] io_wdata,
  output logic          io_gnt,
  output logic          io_done,
  output logic [DW-1:0] io_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] WAIT_C = 4'(WAIT);

  state_t        state_q, state_d;
  logic          own_io_q, own_io_d;
  logic          last_io_q, last_io_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] io_rdata_q, io_rdata_d;
  logic          pick_io;

  always_comb begin
    state_d     = state_q;
    own_io_d    = own_io_q;
    last_io_d   = last_io_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    io_rdata_d  = io_rdata_q;
    // IO wins only when alone or when the CPU was served last
    pick_io     = io_req && (!cpu_req || !last_io_q);
    case (state_q)
      IDLE: begin
        if (cpu_req || io_req) begin
          own_io_d = pick_io;
          we_d     = pick_io ? io_we    : cpu_we;
          addr_d   = pick_io ? io_addr  : cpu_addr;
          wdata_d  = pick_io ? io_wdata : cpu_wdata;
          cnt_d    = WAIT_C;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            if (own_io_q) io_rdata_d  = mem_rdata;
            else          cpu_rdata_d = mem_rdata;
          end
          last_io_d = own_io_q;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      own_io_q    <= 1'b0;
      last_io_q   <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= 4'd0;
      cpu_rdata_q <= '0;
      io_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      own_io_q    <= own_io_d;
      last_io_q   <= last_io_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      io_rdata_q  <= io_rdata_d;
    end
  end

  // Outputs decode straight from state so an async reset drops them immediately
  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = (state_q == ACCESS) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign cpu_gnt   = (state_q != IDLE) && !own_io_q;
  assign io_gnt    = (state_q != IDLE) && own_io_q;
  assign cpu_done  = (state_q == DONE) && !own_io_q;
  assign io_done   = (state_q == DONE) && own_io_q;
  assign cpu_rdata = cpu_rdata_q;
  assign io_rdata  = io_rdata_q;

endmodule
